// File: rtl/drac_pkg.sv
// Shared pipeline types for the fetch/decode boundary.
// Also holds the instruction-buffer depth used by the top-level instantiation.
package drac_pkg;

   typedef logic [39:0] addr_t;
   typedef logic [31:0] inst_t;

   typedef enum logic [3:0] {
      INSTR_ADDR_MISALIGNED = 4'd0,
      INSTR_ACCESS_FAULT    = 4'd1,
      ILLEGAL_INSTR         = 4'd2,
      BREAKPOINT            = 4'd3,
      LD_ADDR_MISALIGNED    = 4'd4,
      LD_ACCESS_FAULT       = 4'd5,
      ST_AMO_ADDR_MISALIGN  = 4'd6,
      ST_AMO_ACCESS_FAULT   = 4'd7,
      INSTR_PAGE_FAULT      = 4'd12,
      NONE                  = 4'd15
   } exception_cause_t;

   typedef struct packed {
      exception_cause_t cause;
      logic [63:0]      origin;
      logic             valid;
   } exception_t;

   typedef enum logic {
      PRED_NOT_TAKEN = 1'b0,
      PRED_TAKEN     = 1'b1
   } branch_pred_decision_t;

   typedef struct packed {
      branch_pred_decision_t decision;
      addr_t                 pred_addr;
   } branch_pred_t;

   typedef struct packed {
      logic         valid;
      addr_t        pc_inst;
      inst_t        inst;
      branch_pred_t bpred;
      exception_t   ex;
   } if_id_stage_t;

   localparam int unsigned IF_ID_FIFO_DEPTH = 4;

endpackage

// File: rtl/if_id_fifo.sv
// Fetch-to-decode instruction buffer: in-order FIFO of if_id_stage_t with flush.
// Optional macro IF_ID_FIFO_BYPASS_EN adds a zero-latency fetch->decode path when empty.
module if_id_fifo
   import drac_pkg::*;
#(
   parameter int unsigned DEPTH = IF_ID_FIFO_DEPTH,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             flush_i,
   input  if_id_stage_t     fetch_i,
   output logic             ready_o,
   output if_id_stage_t     decode_o,
   input  logic             decode_ready_i,
   output logic [PTR_W:0]   count_o
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   if_id_stage_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic             head_valid;
   logic             push;
   logic             wr;
   logic             rd;

   assign head_valid = (count != '0);
   assign ready_o    = (count != FULL_CNT) & rstn_i & ~flush_i;
   assign push       = fetch_i.valid & ready_o;
   assign rd         = head_valid & decode_ready_i & rstn_i;
   assign count_o    = rstn_i ? count : '0;

`ifdef IF_ID_FIFO_BYPASS_EN
   logic bypass;
   assign bypass = ~head_valid & fetch_i.valid & ~flush_i & rstn_i;
   // A bypassed entry taken by decode this cycle never occupies a slot.
   assign wr     = push & ~(bypass & decode_ready_i);
`else
   assign wr     = push;
`endif

   always_comb begin
      decode_o = '0;
      if (rstn_i) begin
         if (head_valid) begin
            decode_o       = mem[rd_ptr];
            decode_o.valid = 1'b1;
         end
`ifdef IF_ID_FIFO_BYPASS_EN
         else if (bypass) begin
            decode_o = fetch_i;
         end
`endif
      end
   end

   // Flush outranks push/pop; ready_o already blocks the write in that cycle.
   always_ff @(posedge clk_i) begin
      if (!rstn_i || flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (rd) rd_ptr <= rd_ptr + 1'b1;
         case ({wr, rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr) mem[wr_ptr] <= fetch_i;
   end

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (rstn_i) begin
         assert (count <= FULL_CNT);
         assert (!(fetch_i.valid && ready_o && count == FULL_CNT));
      end
   end
`endif

endmodule

// File: doc/if_id_fifo.md
Name: if_id_fifo

Overview:
Fetch-to-decode instruction buffer.
- Accepts if_id_stage_t entries from the IF stage through a valid/ready handshake.
- Stores them in order.
- Presents the oldest entry, as an if_id_stage_t, on the decoder input (decode_i of the decoder).
- Decouples fetch from decode stalls and discards all buffered work on a pipeline flush (branch mispredict or exception).

Parameters:
DEPTH, 4, number of entries; power of two, ≥2.
PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rstn_i  input  1  synchronous active-low reset.
flush_i  input  1  discard all entries (mispredict/exception redirect).
fetch_i  input  if_id_stage_t  entry from IF; fetch_i.valid is the push request.
ready_o  output  1  FIFO can accept fetch_i this cycle.
decode_o  output  if_id_stage_t  oldest entry to the decoder; decode_o.valid means an entry is present.
decode_ready_i  input  1  decoder/ID consumes decode_o this cycle (i.e. not stalled).
count_o  output  PTR_W+1  number of stored entries.

Behaviour:
- Reset (rstn_i=0 at edge): rd_ptr=0, wr_ptr=0, count=0.
- While rstn_i=0: ready_o=0, decode_o='0, count_o=0.
- Storage array contents are not reset.
- push = fetch_i.valid & ready_o.
- pop = decode_o.valid & decode_ready_i.
- ready_o = (count != DEPTH) & rstn_i & !flush_i. It is combinational from registered count; there is no dependence on decode_ready_i, so a full FIFO does not accept in the same cycle it pops.
- decode_o = mem[rd_ptr] with valid forced to 1 when count != 0.
  - When count == 0, decode_o = '0; no X may propagate to the decoder.
- Latency without bypass: an entry pushed in cycle N is visible on decode_o in cycle N+1.
- Pointers wrap modulo DEPTH (natural PTR_W overflow).
- count update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on push & pop.
- Flush has priority over push and pop. At the flush edge, count=0 and rd_ptr=wr_ptr=0, and the fetch_i of that cycle is dropped.
  - decode_o in the flush cycle still shows the head entry. ID must ignore it (owned by ID flush logic).
- Entries with fetch_i.ex.valid=1 are stored and forwarded unchanged. No filtering of exception, bpred, pc_inst or inst fields.
- Push while full cannot occur (ready_o=0). Pop while empty cannot occur (valid=0). Neither is an error state.
- Assertion (simulation only): count_o <= DEPTH; no push when count==DEPTH.

Optional Feature:
IF_ID_FIFO_BYPASS_EN.
- Defined, when count==0 and fetch_i.valid=1 and flush_i=0:
  - decode_o = fetch_i combinationally (zero latency).
  - If decode_ready_i=1, the entry is consumed and not written; count stays 0.
  - Otherwise it is written as a normal push.
- Undefined: no combinational path fetch_i→decode_o; 1-cycle minimum latency.

Decomposition:
- if_id_stage_t, exception_t and bpred fields remain in drac_pkg.
- Add to drac_pkg: localparam IF_ID_FIFO_DEPTH = 4, used by the top-level instantiation.
- No sub-module. Pointer/count logic and the storage array are small and stay inline.
- The storage array is a plain flop array of if_id_stage_t (DEPTH ≤ 8 expected; no SRAM macro).

Test Plan:
1. Reset then idle: rstn_i=0 for 2 cycles, release → ready_o=1, count_o=0, decode_o.valid=0 and all decode_o fields 0.
2. Single entry: push pc_inst=40'h2000, inst=32'hfff02013 with decode_ready_i=0 → next cycle decode_o.valid=1, pc 0x2000, inst fff02013, count_o=1.
   - Then decode_ready_i=1 → following cycle count_o=0, valid=0.
3. Fill and order: decode_ready_i=0, push 0x2000/fff02013, 0x2004/00003013, 0x2008/00500013, 0x200C/00804013 → count_o=4, ready_o=0.
   - A fifth push with pc 0x2010 is not accepted.
   - Drain with decode_ready_i=1 → outputs in order 2000, 2004, 2008, 200C; ready_o=1 after the first pop.
4. Wrap-around: hold count at 2 while pushing and popping every cycle for 10 cycles (PCs 0x3000+4k) → output PCs strictly sequential, count_o constant at 2.
5. Flush with simultaneous push: count=3, assert flush_i with fetch_i.valid=1 (pc 0x4000) → next cycle count_o=0, decode_o.valid=0, and 0x4000 never appears.
6. Exception passthrough and reset mid-operation:
   - Push with ex.valid=1, ex.cause=ILLEGAL_INSTR → same ex fields on decode_o.
   - With count=2, pulse rstn_i=0 → count_o=0, ready_o=0 during reset, 1 after release.
